bus_resp_mem: RTL

Memory-side responder for the Ibex instruction/data request protocol (req/gnt/rvalid). It replaces the zero-wait single-port RAM behind the core's shared memory port with a word-addressed memory that has a configurable fixed response latency, a bounded number of outstanding transactions, bench-controlled grant stalls and error responses for out-of-range addresses. It sits between the bench's bus mux and nothing else: it is the terminating slave.

---
 rtl/bus_resp_pkg.sv | 24 ++
 rtl/bus_resp_if.sv | 28 ++
 rtl/bus_resp_pipe.sv | 31 +++
 rtl/bus_resp_mem.sv | 93 +++++++++
 4 files changed

// File: rtl/bus_resp_pkg.sv
// Shared types and helpers for the bus_resp_mem terminating slave.
// Response entries travel through the latency pipe as resp_t.
package bus_resp_pkg;

  localparam int unsigned LatencyMax     = 8;
  localparam int unsigned OutstandingMax = 8;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    logic [33:0] lim;
    lim = {2'b00, depth} << 2;
    return {2'b00, addr - base} < lim;
  endfunction

endpackage

// File: rtl/bus_resp_if.sv
// req/gnt/rvalid bus between a requester and bus_resp_mem.
// Signal names follow the slave's point of view.
interface bus_resp_if;

  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        stall_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i,
    output wdata_i, stall_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i,
    input  wdata_i, stall_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/bus_resp_pipe.sv
// Fixed-latency delay line of response entries.
// Cleared asynchronously so pending responses vanish on reset.
module bus_resp_pipe
  import bus_resp_pkg::*;
#(
  parameter int unsigned Latency = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  resp_t in_i,
  output resp_t out_o
);

  resp_t stage_q [Latency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < Latency; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_o = stage_q[Latency-1];

endmodule

// File: rtl/bus_resp_mem.sv
// Word memory answering req/gnt/rvalid with fixed latency,
// bounded outstanding count, grant stalls and range errors.
module bus_resp_mem
  import bus_resp_pkg::*;
#(
  parameter int unsigned Depth          = 16384,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned Latency        = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input logic       clk_i,
  input logic       rst_ni,
  bus_resp_if.slave bus
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

  logic [31:0]     mem_q [Depth];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx;
  logic            in_range;
  logic            gnt;
  logic            resp_fire;
  logic            wr_en;
  resp_t           push;
  resp_t           pop;

  assign idx       = IdxW'((bus.addr_i - BaseAddr) >> 2);
  assign in_range  = addr_in_range(bus.addr_i, BaseAddr, Depth);
  assign resp_fire = pop.valid;
  assign gnt       = bus.req_i & ~bus.stall_i
                   & ((cnt_q < MaxOut) | resp_fire);
  assign wr_en     = gnt & bus.we_i & in_range;

  always_comb begin
    push       = '0;
    push.valid = gnt;
    push.err   = gnt & ~in_range;
    if (gnt & ~bus.we_i & in_range) begin
      push.rdata = mem_q[idx];
    end
  end

  // Contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) begin
          mem_q[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({gnt, resp_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  bus_resp_pipe #(
    .Latency(Latency)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .in_i  (push),
    .out_o (pop)
  );

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = pop.valid;
  assign bus.rdata_o  = pop.rdata;
  assign bus.err_o    = pop.err;

  a_cnt_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= MaxOut
  );

endmodule
